// File: rtl/striping_2lanes.sv
// striping_2lanes: splits one 32-bit word stream into two lanes.
// Even words go to lane_0 and odd words go to lane_1. The pair is emitted one
// cycle after the odd word is accepted.
// Optional feature macro STRIPE_FLUSH_EN: when it is defined, a lone lane_0
// word that waits FLUSH_CYCLES idle cycles is emitted by itself (valid_1 = 0).
// When it is undefined, a held word waits in HOLD0 indefinitely.
//
// Handshake: the input side is valid-only. data_in is consumed on every
// clk_4f rising edge where valid_in=1, and there is no ready/back-pressure.
// Outputs are qualified by one-cycle valid_0/valid_1 pulses. Lane words hold
// their value between emissions.
module striping_2lanes #(
    // Idle cycles before a forced flush. The legal range is 2..15.
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic [31:0] lane_0,
    output logic [31:0] lane_1,
    output logic        valid_0,
    output logic        valid_1,
    output logic [7:0]  pair_cnt,
    output logic        dbg_state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        HOLD0 = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] lane0_q, lane0_d;
    logic [31:0] lane1_q, lane1_d;
    logic        v0_q, v0_d;
    logic        v1_q, v1_d;
    logic [7:0]  cnt_q, cnt_d;

`ifdef STRIPE_FLUSH_EN
    // Counter value seen on the last idle cycle before the flush fires.
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    logic [3:0]  idle_q, idle_d;
`endif

    // State and datapath registers. Reset clears everything, including any held word.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            lane0_q <= '0;
            lane1_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef STRIPE_FLUSH_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            cnt_q   <= cnt_d;
`ifdef STRIPE_FLUSH_EN
            idle_q  <= idle_d;
`endif
        end
    end

    // Next-state logic: capture the even word, then emit a pair (or a flush).
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lane0_d = lane0_q;
        lane1_d = lane1_q;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        cnt_d   = cnt_q;
`ifdef STRIPE_FLUSH_EN
        idle_d  = idle_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    hold_d  = data_in;
`ifdef STRIPE_FLUSH_EN
                    idle_d  = '0;
`endif
                    state_d = HOLD0;
                end
            end
            HOLD0: begin
                // An arriving word always wins over a pending flush.
                if (valid_in) begin
                    lane0_d = hold_q;
                    lane1_d = data_in;
                    v0_d    = 1'b1;
                    v1_d    = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
`ifdef STRIPE_FLUSH_EN
                else if (idle_q == FLUSH_LAST) begin
                    lane0_d = hold_q;
                    v0_d    = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    idle_d  = idle_q + 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign lane_0      = lane0_q;
    assign lane_1      = lane1_q;
    assign valid_0     = v0_q;
    assign valid_1     = v1_q;
    assign pair_cnt    = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_striping_2lanes.sv
// Directed bench for striping_2lanes (FLUSH_CYCLES = 4). Expectations follow
// the STRIPE_FLUSH_EN build selection.
module tb_striping_2lanes;

    logic        clk_4f;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic [31:0] lane_0;
    logic [31:0] lane_1;
    logic        valid_0;
    logic        valid_1;
    logic [7:0]  pair_cnt;
    logic        dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    striping_2lanes #(.FLUSH_CYCLES(4)) dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .lane_0      (lane_0),
        .lane_1      (lane_1),
        .valid_0     (valid_0),
        .valid_1     (valid_1),
        .pair_cnt    (pair_cnt),
        .dbg_state_o (dbg_state_o)
    );

    // Clock generation
    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        data_in  = '0;
        reset    = 1'b1;
        @(posedge clk_4f);
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_pair(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                              input logic [7:0] cnt);
        check({tag, "_lane0"}, lane_0, l0);
        check({tag, "_lane1"}, lane_1, l1);
        check({tag, "_v0"}, {31'd0, valid_0}, 32'd1);
        check({tag, "_v1"}, {31'd0, valid_1}, 32'd1);
        check({tag, "_cnt"}, {24'd0, pair_cnt}, {24'd0, cnt});
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_v0"}, {31'd0, valid_0}, 32'd0);
        check({tag, "_v1"}, {31'd0, valid_1}, 32'd0);
    endtask

    initial begin
        // Reset state
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        #3;
        check("rst_lane0", lane_0, 32'd0);
        check("rst_lane1", lane_1, 32'd0);
        check("rst_valids", {30'd0, valid_1, valid_0}, 32'd0);
        check("rst_cnt", {24'd0, pair_cnt}, 32'd0);
        check("rst_state", {31'd0, dbg_state_o}, 32'd0);
        @(posedge clk_4f);
        #1;
        reset = 1'b0;

        // Basic pair
        step(1'b1, 32'h0000FFFF);
        check_quiet("p1_first");
        check("p1_state", {31'd0, dbg_state_o}, 32'd1);
        step(1'b1, 32'hFFFFFFFF);
        check_pair("p1", 32'h0000FFFF, 32'hFFFFFFFF, 8'd1);
        step(1'b0, 32'h0);
        check_quiet("p1_after");
        check("p1_hold_lane0", lane_0, 32'h0000FFFF);
        check("p1_hold_lane1", lane_1, 32'hFFFFFFFF);

        // Six back-to-back words
        do_reset();
        for (int i = 1; i <= 6; i += 2) begin
            step(1'b1, 32'(i));
            check_quiet("b2b_gap");
            step(1'b1, 32'(i + 1));
            check_pair("b2b", 32'(i), 32'(i + 1), 8'((i + 1) / 2));
        end
        step(1'b0, 32'h0);
        check_quiet("b2b_end");
        check("b2b_cnt", {24'd0, pair_cnt}, 32'd3);

        // Lone word followed by idle cycles
        do_reset();
        step(1'b1, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0);
            check_quiet("fl_wait");
        end
        step(1'b0, 32'h0);
`ifdef STRIPE_FLUSH_EN
        check("fl_lane0", lane_0, 32'hA5A5A5A5);
        check("fl_lane1", lane_1, 32'h0);
        check("fl_v0", {31'd0, valid_0}, 32'd1);
        check("fl_v1", {31'd0, valid_1}, 32'd0);
        check("fl_cnt", {24'd0, pair_cnt}, 32'd1);
        step(1'b0, 32'h0);
        check_quiet("fl_after");
        check("fl_state", {31'd0, dbg_state_o}, 32'd0);
        // After a flush the next word is a lane_0 word again
        step(1'b1, 32'hB0B0B0B0);
        check_quiet("fl_next_first");
        step(1'b1, 32'hC0C0C0C0);
        check_pair("fl_next", 32'hB0B0B0B0, 32'hC0C0C0C0, 8'd2);
`else
        check_quiet("nofl_4th");
        check("nofl_cnt", {24'd0, pair_cnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0);
            check_quiet("nofl_wait");
        end
        check("nofl_state", {31'd0, dbg_state_o}, 32'd1);
        // The held word still pairs with the next one
        step(1'b1, 32'hB0B0B0B0);
        check_pair("nofl_next", 32'hA5A5A5A5, 32'hB0B0B0B0, 8'd1);
        step(1'b1, 32'hC0C0C0C0);
        check_quiet("nofl_next2");
`endif

        // Second word arriving on the flush cycle wins
        do_reset();
        step(1'b1, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0);
            check_quiet("co_wait");
        end
        step(1'b1, 32'h12345678);
        check_pair("co", 32'hCAFEF00D, 32'h12345678, 8'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            check_quiet("co_after");
        end
        check("co_cnt", {24'd0, pair_cnt}, 32'd1);

        // Reset asserted mid-HOLD0 discards the held word
        step(1'b1, 32'h99);
        check("mr_state", {31'd0, dbg_state_o}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_lane0", lane_0, 32'd0);
        check("mr_lane1", lane_1, 32'd0);
        check("mr_valids", {30'd0, valid_1, valid_0}, 32'd0);
        check("mr_cnt", {24'd0, pair_cnt}, 32'd0);
        check("mr_state_rst", {31'd0, dbg_state_o}, 32'd0);
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            check_quiet("mr_idle");
        end
        step(1'b1, 32'd7);
        check_quiet("mr_first");
        step(1'b1, 32'd8);
        check_pair("mr", 32'd7, 32'd8, 8'd1);

        // pair_cnt wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 32'(2 * i));
            step(1'b1, 32'(2 * i + 1));
        end
        check("wr_cnt255", {24'd0, pair_cnt}, 32'd255);
        step(1'b1, 32'hDEAD0000);
        check_quiet("wr_gap");
        step(1'b1, 32'hDEAD0001);
        check_pair("wr", 32'hDEAD0000, 32'hDEAD0001, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/striping_2lanes.md
STRIPING_2LANES -- requirements
Module: striping_2lanes

Interface
REQ-001 Parameter FLUSH_CYCLES, default 4, SHALL set the idle cycles (range 2..15) a lone lane_0 word waits before a forced flush.
REQ-002 clk_4f  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 data_in  input  32  word from the serial stream.
REQ-005 valid_in  input  1  data_in SHALL be accepted on every clk_4f edge where valid_in=1 (no back-pressure).
REQ-006 lane_0, lane_1  output  32 each  registered lane words.
REQ-007 valid_0, valid_1  output  1 each  per-lane qualifiers, one-cycle pulses.
REQ-008 pair_cnt  output  8  count of emitted lane transfers.

Function
REQ-009 FSM SHALL have exactly two states: IDLE (no word held) and HOLD0 (one word held for lane_0).
REQ-010 In IDLE with valid_in=1, data_in SHALL be captured into a hold register, idle counter cleared to 0, next state HOLD0; outputs SHALL NOT pulse.
REQ-011 In IDLE with valid_in=0, the block SHALL stay in IDLE, and valid_0 and valid_1 SHALL be 0.
REQ-012 In HOLD0 with valid_in=1, the block SHALL drive lane_0 = held word, lane_1 = data_in, valid_0=valid_1=1 in the following cycle, then return to IDLE.
REQ-013 Latency SHALL be one cycle: the pair is visible the cycle after the edge that accepts the second word.
REQ-014 In HOLD0 with valid_in=0, the idle counter SHALL increment by 1 per cycle.
REQ-015 Flush: in HOLD0, when the counter equals FLUSH_CYCLES-1 and valid_in=0, the block SHALL drive lane_0 = held word, valid_0=1, valid_1=0, lane_1 unchanged, then go to IDLE.
REQ-016 When the flush condition and valid_in=1 coincide, the arriving word SHALL win; a full pair is emitted per REQ-012 and no flush occurs.
REQ-017 valid_0/valid_1 SHALL be high for exactly one cycle per emission.
REQ-018 lane_0/lane_1 SHALL hold their last value when not emitting.
REQ-019 pair_cnt SHALL increment by 1 on each emission, pair or flush, and SHALL wrap from 255 to 0.
REQ-020 Word order SHALL be preserved: stream word 2k goes to lane_0 and word 2k+1 goes to lane_1, counted from reset or from the last flush.
REQ-021 Back-to-back valid_in SHALL sustain one pair every 2 cycles with no dropped words.

Reset
REQ-022 While reset=1, lane_0=lane_1=0, valid_0=valid_1=0, pair_cnt=0, state=IDLE, idle counter=0, hold register=0, independent of clk_4f.
REQ-023 Reset asserted in HOLD0 SHALL discard the held word; no emission SHALL follow.
REQ-024 The first valid_in after reset deassertion SHALL be treated as a lane_0 word.

Configuration
REQ-025 Macro STRIPE_FLUSH_EN defined: the flush mechanism of REQ-014..016 SHALL be compiled in.
REQ-026 Macro STRIPE_FLUSH_EN undefined: the idle counter and flush logic SHALL be absent, a held word SHALL wait in HOLD0 indefinitely, and valid_1=0 emissions SHALL never occur.

Verification
REQ-027 Reset, then valid_in=1 for two cycles with 32'h0000FFFF, 32'hFFFFFFFF -> next cycle lane_0=32'h0000FFFF, lane_1=32'hFFFFFFFF, valid_0=valid_1=1, pair_cnt=1.
REQ-028 Six consecutive valid words 1..6 -> three pairs (1,2), (3,4), (5,6) on alternate cycles, pair_cnt=3, valids low between pairs.
REQ-029 With STRIPE_FLUSH_EN defined and FLUSH_CYCLES=4: one word 32'hA5A5A5A5 followed by 4 idle cycles -> lane_0=32'hA5A5A5A5, valid_0=1, valid_1=0, lane_1 unchanged; with the macro undefined -> no pulse ever.
REQ-030 Second word 32'h12345678 arriving exactly on the flush cycle -> full pair emitted, valid_1=1, no separate flush pulse.
REQ-031 Reset pulsed mid-HOLD0, then words 7, 8 -> only pair (7,8) emitted, all outputs 0 during reset, pair_cnt counts from 0.
REQ-032 256 consecutive pairs -> pair_cnt wraps to 0 on the 256th emission.
